// File: rtl/lsp_stability_fsm_pkg.sv
// Shared constants, state encoding and small helpers for the LSF stability sequencer.
// Imported by the interface-facing top so the limits live in one place.
package lsp_stability_fsm_pkg;

   localparam int          M       = 10;
   localparam logic [15:0] L_LIMIT = 16'd40;
   localparam logic [15:0] M_LIMIT = 16'd25681;
   localparam logic [15:0] GAP3    = 16'd321;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_LOAD0,
      ST_SORT,
      ST_SWAP,
      ST_P2_RD,
      ST_P2_LO,
      ST_GAP,
      ST_CLAMP_HI
   } state_e;

   // Element k of the vector sits in the 16-word page selected by base[11:4].
   function automatic logic [11:0] elemAddr(input logic [11:0] base, input logic [3:0] k);
      return {base[11:4], k};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/lsp_stability_fsm_if.sv
// Bundle of control, scratch-memory and shared-operator signals for the stability sequencer.
// master is the sequencer side; slave is the parent that owns memory and operators.
interface lsp_stability_fsm_if;

   logic        start;
   logic [11:0] lsfAddr;
   logic [31:0] memIn;
   logic [11:0] memReadAddr;
   logic [11:0] memWriteAddr;
   logic [31:0] memOut;
   logic        memWriteEn;
   logic [31:0] L_subOutA;
   logic [31:0] L_subOutB;
   logic [31:0] L_subIn;
   logic [15:0] addOutA;
   logic [15:0] addOutB;
   logic [15:0] addIn;
   logic        done;

   modport master (
      input  start, lsfAddr, memIn, L_subIn, addIn,
      output memReadAddr, memWriteAddr, memOut, memWriteEn,
             L_subOutA, L_subOutB, addOutA, addOutB, done
   );

   modport slave (
      output start, lsfAddr, memIn, L_subIn, addIn,
      input  memReadAddr, memWriteAddr, memOut, memWriteEn,
             L_subOutA, L_subOutB, addOutA, addOutB, done
   );

endinterface

// File: rtl/lsp_stability_fsm.sv
// In-place LSF stability pass: one bubble pass, low clamp, minimum gap, high clamp.
// Streams the vector through a 1-cycle-latency memory, using the parent's shared L_sub/add.
module lsp_stability_fsm
   import lsp_stability_fsm_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   lsp_stability_fsm_if.master bus
);

   localparam logic [3:0] LAST_IDX = 4'(M - 1);
   localparam logic [3:0] PAIR_END = 4'(M - 2);

   state_e      state_q, state_d;
   logic [15:0] prev_q, prev_d;
   logic [3:0]  idx_q, idx_d;

   logic [3:0]  idxP1;
   logic [3:0]  idxP2;
   logic [15:0] x;
   logic        lsubNeg;
   logic        gapShort;
   logic        unusedMemHi;

   assign idxP1       = idx_q + 4'd1;
   assign idxP2       = idx_q + 4'd2;
   assign x           = bus.memIn[15:0];
   assign lsubNeg     = bus.L_subIn[31];
   assign gapShort    = $signed(bus.L_subIn) < $signed({16'd0, GAP3});
   assign unusedMemHi = ^bus.memIn[31:16];

   // prev always holds the running "larger" element in the bubble pass and the
   // last accepted element in the gap pass, so each element is read only once.
   always_comb begin
      state_d          = state_q;
      prev_d           = prev_q;
      idx_d            = idx_q;
      bus.memReadAddr  = 12'd0;
      bus.memWriteAddr = 12'd0;
      bus.memOut       = 32'd0;
      bus.memWriteEn   = 1'b0;
      bus.L_subOutA    = 32'd0;
      bus.L_subOutB    = 32'd0;
      bus.addOutA      = 16'd0;
      bus.addOutB      = 16'd0;
      bus.done         = 1'b0;
      case (state_q)
         ST_INIT: begin
            prev_d = 16'd0;
            idx_d  = 4'd0;
            if (bus.start) begin
               bus.memReadAddr = elemAddr(bus.lsfAddr, 4'd0);
               state_d         = ST_LOAD0;
            end
         end
         ST_LOAD0: begin
            prev_d          = x;
            idx_d           = 4'd0;
            bus.memReadAddr = elemAddr(bus.lsfAddr, 4'd1);
            state_d         = ST_SORT;
         end
         ST_SORT: begin
            bus.L_subOutA = sext16(x);
            bus.L_subOutB = sext16(prev_q);
            if (lsubNeg) begin
               bus.memWriteEn   = 1'b1;
               bus.memWriteAddr = elemAddr(bus.lsfAddr, idx_q);
               bus.memOut       = sext16(x);
               state_d          = ST_SWAP;
            end else begin
               prev_d = x;
               idx_d  = idxP1;
               if (idx_q < PAIR_END) begin
                  bus.memReadAddr = elemAddr(bus.lsfAddr, idxP2);
               end else begin
                  state_d = ST_P2_RD;
               end
            end
         end
         ST_SWAP: begin
            bus.memWriteEn   = 1'b1;
            bus.memWriteAddr = elemAddr(bus.lsfAddr, idxP1);
            bus.memOut       = sext16(prev_q);
            idx_d            = idxP1;
            if (idxP1 < LAST_IDX) begin
               bus.memReadAddr = elemAddr(bus.lsfAddr, idxP2);
               state_d         = ST_SORT;
            end else begin
               state_d = ST_P2_RD;
            end
         end
         ST_P2_RD: begin
            bus.memReadAddr = elemAddr(bus.lsfAddr, 4'd0);
            state_d         = ST_P2_LO;
         end
         ST_P2_LO: begin
            bus.L_subOutA = sext16(x);
            bus.L_subOutB = sext16(L_LIMIT);
            if (lsubNeg) begin
               prev_d           = L_LIMIT;
               bus.memWriteEn   = 1'b1;
               bus.memWriteAddr = elemAddr(bus.lsfAddr, 4'd0);
               bus.memOut       = sext16(L_LIMIT);
            end else begin
               prev_d = x;
            end
            idx_d           = 4'd0;
            bus.memReadAddr = elemAddr(bus.lsfAddr, 4'd1);
            state_d         = ST_GAP;
         end
         ST_GAP: begin
            bus.L_subOutA = sext16(x);
            bus.L_subOutB = sext16(prev_q);
            bus.addOutA   = prev_q;
            bus.addOutB   = GAP3;
            if (gapShort) begin
               bus.memWriteEn   = 1'b1;
               bus.memWriteAddr = elemAddr(bus.lsfAddr, idxP1);
               bus.memOut       = sext16(bus.addIn);
               prev_d           = bus.addIn;
            end else begin
               prev_d = x;
            end
            idx_d = idxP1;
            if (idx_q < PAIR_END) begin
               bus.memReadAddr = elemAddr(bus.lsfAddr, idxP2);
            end else begin
               state_d = ST_CLAMP_HI;
            end
         end
         ST_CLAMP_HI: begin
            bus.L_subOutA = sext16(M_LIMIT);
            bus.L_subOutB = sext16(prev_q);
            if (lsubNeg) begin
               bus.memWriteEn   = 1'b1;
               bus.memWriteAddr = elemAddr(bus.lsfAddr, LAST_IDX);
               bus.memOut       = sext16(M_LIMIT);
            end
            bus.done = 1'b1;
            state_d  = ST_INIT;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Synchronous reset returns to INIT and abandons any partially processed vector.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;
         prev_q  <= 16'd0;
         idx_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_lsp_stability_fsm.sv
// Self-checking bench for lsp_stability_fsm: models memory and shared operators,
// and compares final vectors, latency and write counts against a direct C-style model.
module tb_lsp_stability_fsm;

   localparam int TB_L_LIMIT = 40;
   localparam int TB_M_LIMIT = 25681;
   localparam int TB_GAP3    = 321;

   typedef logic signed [15:0] vec_t [10];

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lsp_stability_fsm_if bus();

   lsp_stability_fsm dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   logic [31:0] mem [0:4095];
   logic        tbWe;
   logic [11:0] tbAddr;
   logic [31:0] tbData;

   int          checks       = 0;
   int          failures     = 0;
   int          writeCount   = 0;
   int          addrErrCount = 0;
   int          extErrCount  = 0;
   logic [31:0] lastWriteData;
   logic [11:0] lastWriteAddr;

   function automatic logic [31:0] lsubModel(input logic [31:0] a, input logic [31:0] b);
      longint d;
      d = longint'($signed(a)) - longint'($signed(b));
      if (d > 64'sd2147483647) return 32'h7fff_ffff;
      if (d < -64'sd2147483648) return 32'h8000_0000;
      return 32'(d);
   endfunction

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic [15:0] addModel(input logic [15:0] a, input logic [15:0] b);
      return 16'(sat16(int'($signed(a)) + int'($signed(b))));
   endfunction

   assign bus.L_subIn = lsubModel(bus.L_subOutA, bus.L_subOutB);
   assign bus.addIn   = addModel(bus.addOutA, bus.addOutB);

   // Scratch memory with 1-cycle read latency; the bench preloads through its own port.
   always @(posedge clk) begin
      bus.memIn <= mem[bus.memReadAddr];
      if (tbWe) begin
         mem[tbAddr] <= tbData;
      end else if (bus.memWriteEn === 1'b1) begin
         mem[bus.memWriteAddr] <= bus.memOut;
         writeCount    <= writeCount + 1;
         lastWriteData <= bus.memOut;
         lastWriteAddr <= bus.memWriteAddr;
         if (bus.memWriteAddr[11:4] !== bus.lsfAddr[11:4]) addrErrCount <= addrErrCount + 1;
         if (bus.memOut[31:16] !== {16{bus.memOut[15]}}) extErrCount <= extErrCount + 1;
      end
   end

   // Straight transcription of Lsp_stability on integers.
   task automatic refModel(input vec_t vin, output vec_t vout, output int swaps, output int writes);
      int b[10];
      int t;
      for (int k = 0; k < 10; k++) b[k] = int'(vin[k]);
      swaps  = 0;
      writes = 0;
      for (int j = 0; j < 9; j++) begin
         if (b[j+1] < b[j]) begin
            t = b[j]; b[j] = b[j+1]; b[j+1] = t;
            swaps++;
            writes += 2;
         end
      end
      if (b[0] < TB_L_LIMIT) begin
         b[0] = TB_L_LIMIT;
         writes++;
      end
      for (int i = 0; i < 9; i++) begin
         if (b[i+1] - b[i] < TB_GAP3) begin
            b[i+1] = sat16(b[i] + TB_GAP3);
            writes++;
         end
      end
      if (b[9] > TB_M_LIMIT) begin
         b[9] = TB_M_LIMIT;
         writes++;
      end
      for (int k = 0; k < 10; k++) vout[k] = 16'(b[k]);
   endtask

   task automatic applyStimulus(input logic [11:0] base, input vec_t v);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         tbWe   = 1'b1;
         tbAddr = {base[11:4], 4'(k)};
         tbData = {{16{v[k][15]}}, v[k]};
      end
      @(negedge clk);
      tbWe = 1'b0;
      bus.lsfAddr = base;
   endtask

   task automatic readBack(input logic [11:0] base, output vec_t v);
      logic [31:0] w;
      for (int k = 0; k < 10; k++) begin
         w    = mem[{base[11:4], 4'(k)}];
         v[k] = w[15:0];
      end
   endtask

   // Caller has start high in cycle 0; returns in the cycle where done is seen (-1 on timeout).
   task automatic runAndTime(input bit keepStart, output int lat);
      lat = -1;
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk);
         #1;
         if (!keepStart) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.lsfAddr = 12'h000;
      tbWe = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.memWriteEn !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_strobes done=%b we=%b required 0/0", bus.done, bus.memWriteEn);
      end
      checks++;
      if (bus.memReadAddr !== 12'd0 || bus.memWriteAddr !== 12'd0 || bus.memOut !== 32'd0) begin
         failures++;
         $display("[TB] FAIL reset_mem_outputs ra=%h wa=%h wd=%h required 0", bus.memReadAddr, bus.memWriteAddr, bus.memOut);
      end
      checks++;
      if (bus.L_subOutA !== 32'd0 || bus.L_subOutB !== 32'd0 || bus.addOutA !== 16'd0 || bus.addOutB !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_op_outputs lsA=%h lsB=%h aA=%h aB=%h required 0", bus.L_subOutA, bus.L_subOutB, bus.addOutA, bus.addOutB);
      end
   endtask

   task automatic test_directed;
      vec_t dv [5];
      vec_t got, exp;
      int   swaps, writes, lat, wc0, ae0, ee0;
      logic [11:0] base;
      for (int k = 0; k < 10; k++) begin
         dv[0][k] = 16'(1000 * (k + 1));
         dv[1][k] = 16'(1000 * (k + 1));
         dv[2][k] = 16'(1000 * (k + 1));
         dv[3][k] = 16'(100 + 10 * k);
         dv[4][k] = 16'(1000 * (k + 1));
      end
      dv[1][3] = 16'sd5000;
      dv[1][4] = 16'sd4000;
      dv[2][0] = 16'sd10;
      dv[4][9] = 16'sd30000;
      for (int t = 0; t < 5; t++) begin
         base = 12'h3A0 + 12'(t * 16) + 12'(t);
         applyStimulus(base, dv[t]);
         refModel(dv[t], exp, swaps, writes);
         wc0 = writeCount; ae0 = addrErrCount; ee0 = extErrCount;
         @(negedge clk);
         bus.start = 1'b1;
         runAndTime(1'b0, lat);
         @(posedge clk);
         #1;
         readBack(base, got);
         for (int k = 0; k < 10; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
               failures++;
               $display("[TB] FAIL directed%0d_buf%0d got=%0d required=%0d", t, k, got[k], exp[k]);
            end
         end
         checks++;
         if (lat !== 22 + swaps) begin
            failures++;
            $display("[TB] FAIL directed%0d_latency got=%0d required=%0d", t, lat, 22 + swaps);
         end
         checks++;
         if (writeCount - wc0 !== writes || addrErrCount !== ae0 || extErrCount !== ee0) begin
            failures++;
            $display("[TB] FAIL directed%0d_writes got=%0d required=%0d addrErr=%0d extErr=%0d",
                     t, writeCount - wc0, writes, addrErrCount - ae0, extErrCount - ee0);
         end
         if (t == 4) begin
            checks++;
            if (lastWriteData !== 32'h0000_6451 || lastWriteAddr !== {base[11:4], 4'd9}) begin
               failures++;
               $display("[TB] FAIL directed_clamp_hi_word data=%h addr=%h required 00006451 at %h",
                        lastWriteData, lastWriteAddr, {base[11:4], 4'd9});
            end
         end
      end
   endtask

   task automatic test_random;
      vec_t v, got, exp;
      int   swaps, writes, lat, wc0, mode, acc;
      logic [11:0] base;
      for (int n = 0; n < 25; n++) begin
         mode = int'($urandom_range(0, 2));
         acc  = int'($urandom_range(0, 20000));
         for (int k = 0; k < 10; k++) begin
            case (mode)
               0: v[k] = 16'($urandom);
               1: begin
                  acc  = acc + int'($urandom_range(0, 700));
                  v[k] = 16'(sat16(acc));
               end
               default: v[k] = 16'($urandom_range(0, 32000));
            endcase
         end
         base = 12'($urandom);
         applyStimulus(base, v);
         refModel(v, exp, swaps, writes);
         wc0 = writeCount;
         @(negedge clk);
         bus.start = 1'b1;
         runAndTime(1'b0, lat);
         @(posedge clk);
         #1;
         readBack(base, got);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("[TB] FAIL random%0d_vector got0=%0d got9=%0d required0=%0d required9=%0d",
                     n, got[0], got[9], exp[0], exp[9]);
         end
         checks++;
         if (lat !== 22 + swaps || writeCount - wc0 !== writes) begin
            failures++;
            $display("[TB] FAIL random%0d_timing latency=%0d required=%0d writes=%0d required=%0d",
                     n, lat, 22 + swaps, writeCount - wc0, writes);
         end
      end
   endtask

   task automatic test_back_to_back;
      vec_t v, r1, r2, got;
      int   s1, s2, w1, w2, lat1, lat2;
      logic [11:0] base;
      base = 12'h5C7;
      for (int k = 0; k < 10; k++) v[k] = 16'(9000 - 700 * k);
      applyStimulus(base, v);
      refModel(v, r1, s1, w1);
      refModel(r1, r2, s2, w2);
      @(negedge clk);
      bus.start = 1'b1;
      runAndTime(1'b1, lat1);
      checks++;
      if (lat1 !== 22 + s1) begin
         failures++;
         $display("[TB] FAIL b2b_first_latency got=%0d required=%0d", lat1, 22 + s1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.memReadAddr !== {base[11:4], 4'd0} || bus.done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_retrigger ra=%h done=%b required %h/0", bus.memReadAddr, bus.done, {base[11:4], 4'd0});
      end
      runAndTime(1'b0, lat2);
      @(posedge clk);
      #1;
      readBack(base, got);
      checks++;
      if (lat2 !== 22 + s2) begin
         failures++;
         $display("[TB] FAIL b2b_second_latency got=%0d required=%0d", lat2, 22 + s2);
      end
      checks++;
      if (got !== r2) begin
         failures++;
         $display("[TB] FAIL b2b_vector got0=%0d got9=%0d required0=%0d required9=%0d", got[0], got[9], r2[0], r2[9]);
      end
   endtask

   task automatic test_reset_midrun;
      vec_t v, mid, got, exp;
      int   swaps, writes, lat, wc0;
      logic [11:0] base;
      base = 12'h7E0;
      for (int k = 0; k < 10; k++) v[k] = 16'(5000 - 450 * k);
      applyStimulus(base, v);
      @(negedge clk);
      bus.start = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput: begin
         checks++;
         if (bus.memWriteEn !== 1'b0 || bus.done !== 1'b0 || bus.memReadAddr !== 12'd0 ||
             bus.memOut !== 32'd0 || bus.L_subOutA !== 32'd0 || bus.addOutA !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midrun_reset_outputs we=%b done=%b ra=%h wd=%h lsA=%h aA=%h required all 0",
                     bus.memWriteEn, bus.done, bus.memReadAddr, bus.memOut, bus.L_subOutA, bus.addOutA);
         end
      end
      wc0 = writeCount;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (writeCount !== wc0) begin
         failures++;
         $display("[TB] FAIL midrun_no_writes got=%0d extra writes required=0", writeCount - wc0);
      end
      readBack(base, mid);
      refModel(mid, exp, swaps, writes);
      @(negedge clk);
      bus.start = 1'b1;
      runAndTime(1'b0, lat);
      @(posedge clk);
      #1;
      readBack(base, got);
      checks++;
      if (got !== exp || lat !== 22 + swaps) begin
         failures++;
         $display("[TB] FAIL midrun_restart got0=%0d required0=%0d latency=%0d required=%0d",
                  got[0], exp[0], lat, 22 + swaps);
      end
   endtask

   initial begin
      tbWe   = 1'b0;
      tbAddr = 12'd0;
      tbData = 32'd0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
